// File: rtl/eth_tx_sched.sv
// Ethernet TX scheduler: round-robin arbitration between two frame sources,
// payload streaming with minimum-size padding, frame-end wait and inter-frame gap.
module eth_tx_sched #(
  parameter int unsigned N            = 2,
  parameter int unsigned IFG_CYCLES   = 96 / N,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [10:0]   len0,
  input  logic [10:0]   len1,
  input  logic [15:0]   etype0,
  input  logic [15:0]   etype1,
  input  logic [47:0]   dest_mac0,
  input  logic [47:0]   dest_mac1,
  input  logic [N-1:0]  data0,
  input  logic [N-1:0]  data1,
  output logic [1:0]    gnt,
  output logic [1:0]    rd,
  output logic          tx_axiiv,
  output logic [N-1:0]  tx_axiid,
  output logic [15:0]   tx_etype,
  output logic [47:0]   tx_dest_mac,
  input  logic          tx_axiov,
  output logic          busy,
  output logic          err
);

  localparam int unsigned LEN_W   = 11;
  localparam int unsigned CNT_W   = 14;   // 12000 beats fit without wrap
  localparam int unsigned MAX_LEN = 1500;
  localparam int unsigned MIN_LEN = 46;
  localparam int unsigned BPB     = 8 / N; // beats per byte

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_PAD,
    S_WAIT_DONE,
    S_IFG
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               gidx, gidx_n;
  logic               last, last_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [1:0]         gnt_n;
  logic [15:0]        etype_n;
  logic [47:0]        mac_n;
  logic               busy_n, err_n;
  logic               axiov_q;
  logic               win;
  logic [LEN_W-1:0]   len_sel;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

  function automatic logic [CNT_W-1:0] stream_beats(input logic [LEN_W-1:0] l);
    return CNT_W'(l) * CNT_W'(BPB);
  endfunction

  // Only meaningful for l < MIN_LEN
  function automatic logic [CNT_W-1:0] pad_beats(input logic [LEN_W-1:0] l);
    return CNT_W'(LEN_W'(MIN_LEN) - l) * CNT_W'(BPB);
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      gidx        <= 1'b0;
      last        <= 1'b1;   // requester 0 wins the first tie
      len_q       <= '0;
      gnt         <= '0;
      tx_etype    <= '0;
      tx_dest_mac <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      axiov_q     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gidx        <= gidx_n;
      last        <= last_n;
      len_q       <= len_n;
      gnt         <= gnt_n;
      tx_etype    <= etype_n;
      tx_dest_mac <= mac_n;
      busy        <= busy_n;
      err         <= err_n;
      axiov_q     <= tx_axiov;
    end
  end

  // Next-state, arbitration and latch logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gidx_n  = gidx;
    last_n  = last;
    len_n   = len_q;
    gnt_n   = gnt;
    etype_n = tx_etype;
    mac_n   = tx_dest_mac;
    err_n   = 1'b0;
    win     = 1'b0;
    len_sel = '0;

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          win     = (req == 2'b11) ? ~last : req[1];
          len_sel = clamp_len(win ? len1 : len0);
          gidx_n  = win;
          last_n  = win;
          len_n   = len_sel;
          gnt_n   = win ? 2'b10 : 2'b01;
          etype_n = win ? etype1 : etype0;
          mac_n   = win ? dest_mac1 : dest_mac0;
          if (len_sel == '0) begin
            state_n = S_PAD;
            cnt_n   = pad_beats(len_sel) - CNT_W'(1);
          end else begin
            state_n = S_STREAM;
            cnt_n   = stream_beats(len_sel) - CNT_W'(1);
          end
        end
      end

      S_STREAM: begin
        if (cnt == '0) begin
          if (len_q < LEN_W'(MIN_LEN)) begin
            state_n = S_PAD;
            cnt_n   = pad_beats(len_q) - CNT_W'(1);
          end else begin
            state_n = S_WAIT_DONE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_PAD: begin
        if (cnt == '0) begin
          state_n = S_WAIT_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (axiov_q && !tx_axiov) begin
          state_n = S_IFG;
          gnt_n   = '0;
          cnt_n   = CNT_W'(IFG_CYCLES - 1);
        end else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
          state_n = S_IFG;
          gnt_n   = '0;
          err_n   = 1'b1;
          cnt_n   = CNT_W'(IFG_CYCLES - 1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_IFG: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        gnt_n   = '0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // Streaming datapath: valid, data mux and read strobes follow the state directly
  always_comb begin
    tx_axiiv = (state == S_STREAM) || (state == S_PAD);
    tx_axiid = '0;
    rd       = 2'b00;
    if (state == S_STREAM) begin
      tx_axiid = gidx ? data1 : data0;
      rd       = gidx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: N=2 and N=4 instances, expected beats queued per frame.
module tb_eth_tx_sched;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] rd;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req2, req4;
  logic [10:0] len0, len1;
  logic [15:0] etype0, etype1;
  logic [47:0] mac0, mac1;
  logic        axiov2, axiov4;
  logic [7:0]  p20 = 8'd0, p21 = 8'd0, p40 = 8'd0, p41 = 8'd0;

  logic [1:0]  gnt2, rd2, gnt4, rd4;
  logic        axiiv2, axiiv4, busy2, busy4, err2, err4;
  logic [1:0]  axiid2;
  logic [3:0]  axiid4;
  logic [15:0] etype_o2, etype_o4;
  logic [47:0] mac_o2, mac_o4;

  int vectors = 0;
  int miscompares = 0;
  beat_t exp_q[$];

  logic        sel4;
  logic        m_axiiv, m_busy, m_err;
  logic [3:0]  m_axiid;
  logic [1:0]  m_rd, m_gnt;

  eth_tx_sched #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .len0(len0), .len1(len1),
    .etype0(etype0), .etype1(etype1), .dest_mac0(mac0), .dest_mac1(mac1),
    .data0(p20[1:0]), .data1(p21[1:0]), .gnt(gnt2), .rd(rd2),
    .tx_axiiv(axiiv2), .tx_axiid(axiid2), .tx_etype(etype_o2), .tx_dest_mac(mac_o2),
    .tx_axiov(axiov2), .busy(busy2), .err(err2)
  );

  eth_tx_sched #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .len0(len0), .len1(len1),
    .etype0(etype0), .etype1(etype1), .dest_mac0(mac0), .dest_mac1(mac1),
    .data0(p40[3:0]), .data1(p41[3:0]), .gnt(gnt4), .rd(rd4),
    .tx_axiiv(axiiv4), .tx_axiid(axiid4), .tx_etype(etype_o4), .tx_dest_mac(mac_o4),
    .tx_axiov(axiov4), .busy(busy4), .err(err4)
  );

  // Payload sources advance one beat per consumed cycle
  always @(posedge clk) begin
    if (rd2[0]) p20 <= p20 + 8'd1;
    if (rd2[1]) p21 <= p21 + 8'd1;
    if (rd4[0]) p40 <= p40 + 8'd1;
    if (rd4[1]) p41 <= p41 + 8'd1;
  end

  // Observation mux for the instance under test
  always_comb begin
    if (sel4) begin
      m_axiiv = axiiv4; m_axiid = axiid4; m_rd = rd4; m_gnt = gnt4;
      m_busy = busy4; m_err = err4;
    end else begin
      m_axiiv = axiiv2; m_axiid = {2'b00, axiid2}; m_rd = rd2; m_gnt = gnt2;
      m_busy = busy2; m_err = err2;
    end
  end

  task automatic push_frame(input int g, input int len);
    int l, nb, st, pd;
    logic [7:0] seed;
    logic [3:0] mask;
    beat_t b;
    nb   = sel4 ? 4 : 2;
    mask = sel4 ? 4'hf : 4'h3;
    seed = sel4 ? ((g == 1) ? p41 : p40) : ((g == 1) ? p21 : p20);
    l    = (len > 1500) ? 1500 : len;
    st   = l * 8 / nb;
    pd   = (l < 46) ? (46 - l) * 8 / nb : 0;
    for (int i = 0; i < st; i++) begin
      b.d  = 4'(seed + 8'(i)) & mask;
      b.rd = (g == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(b);
    end
    for (int i = 0; i < pd; i++) begin
      b.d  = 4'h0;
      b.rd = 2'b00;
      exp_q.push_back(b);
    end
  endtask

  task automatic collect_frame(input int g, input logic [1:0] req_after, input string name);
    int guard;
    beat_t e;
    logic [1:0] eg;
    eg = (g == 1) ? 2'b10 : 2'b01;
    guard = 0;
    while (!m_axiiv && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!m_axiiv) begin
      miscompares++;
      $display("FAIL %s start: tx_axiiv=0 after 200 cycles, required 1", name);
      exp_q.delete();
      return;
    end
    if (sel4) req4 = req_after; else req2 = req_after;
    guard = 0;
    while (m_axiiv && guard < 7000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s extra beat %0d: tx_axiiv=1, required 0", name, guard);
      end else begin
        e = exp_q.pop_front();
        if ({m_axiid, m_rd, m_gnt} !== {e.d, e.rd, eg}) begin
          miscompares++;
          $display("FAIL %s beat %0d: got axiid=%h rd=%b gnt=%b, required axiid=%h rd=%b gnt=%b",
                   name, guard, m_axiid, m_rd, m_gnt, e.d, e.rd, eg);
        end
      end
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s length: frame ended with %0d beats missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Transmitter finishes: one-cycle tx_axiov pulse, returns on the first IFG cycle
  task automatic finish_frame();
    if (sel4) axiov4 = 1'b1; else axiov2 = 1'b1;
    @(negedge clk);
    axiov4 = 1'b0;
    axiov2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (m_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (m_busy) begin
      miscompares++;
      $display("FAIL %s idle: busy=1 after 200 cycles, required 0", name);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gnt2, rd2, axiiv2, axiid2, etype_o2, mac_o2, busy2, err2} !== '0) begin
      miscompares++;
      $display("FAIL reset_n2: got gnt=%b rd=%b v=%b d=%h et=%h mac=%h busy=%b err=%b, required all 0",
               gnt2, rd2, axiiv2, axiid2, etype_o2, mac_o2, busy2, err2);
    end
    vectors++;
    if ({gnt4, rd4, axiiv4, axiid4, etype_o4, mac_o4, busy4, err4} !== '0) begin
      miscompares++;
      $display("FAIL reset_n4: got gnt=%b rd=%b v=%b d=%h et=%h mac=%h busy=%b err=%b, required all 0",
               gnt4, rd4, axiiv4, axiid4, etype_o4, mac_o4, busy4, err4);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy2, gnt2, axiiv2} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: got busy=%b gnt=%b v=%b, required 0 0 0", busy2, gnt2, axiiv2);
    end
  endtask

  task automatic test_single();
    sel4 = 1'b0;
    len0 = 11'd60; etype0 = 16'h0800; mac0 = 48'h0011_2233_4455;
    req2 = 2'b01;
    push_frame(0, 60);
    @(negedge clk);
    vectors++;
    if ({gnt2, busy2, etype_o2, mac_o2} !== {2'b01, 1'b1, 16'h0800, 48'h0011_2233_4455}) begin
      miscompares++;
      $display("FAIL single_grant: got gnt=%b busy=%b et=%h mac=%h, required 01 1 0800 001122334455",
               gnt2, busy2, etype_o2, mac_o2);
    end
    etype0 = 16'hdead;
    collect_frame(0, 2'b00, "single");
    vectors++;
    if ({gnt2, etype_o2} !== {2'b01, 16'h0800}) begin
      miscompares++;
      $display("FAIL single_hold: got gnt=%b et=%h, required 01 0800", gnt2, etype_o2);
    end
    finish_frame();
    wait_idle("single");
  endtask

  task automatic test_round_robin();
    reset_dut();
    len0 = 11'd64; len1 = 11'd64; etype1 = 16'h86dd; mac1 = 48'hffff_ffff_ffff;
    req2 = 2'b11;
    push_frame(0, 64);
    @(negedge clk);
    vectors++;
    if (gnt2 !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_first: got gnt=%b, required 01", gnt2);
    end
    collect_frame(0, 2'b11, "rr0");
    finish_frame();
    push_frame(1, 64);
    collect_frame(1, 2'b00, "rr1");
    vectors++;
    if ({etype_o2, mac_o2} !== {16'h86dd, 48'hffff_ffff_ffff}) begin
      miscompares++;
      $display("FAIL rr_latch1: got et=%h mac=%h, required 86dd ffffffffffff", etype_o2, mac_o2);
    end
    finish_frame();
    wait_idle("rr");
  endtask

  task automatic test_pad_n4();
    sel4 = 1'b1;
    len1 = 11'd10;
    req4 = 2'b10;
    push_frame(1, 10);
    @(negedge clk);
    vectors++;
    if (gnt4 !== 2'b10) begin
      miscompares++;
      $display("FAIL n4_grant: got gnt=%b, required 10", gnt4);
    end
    collect_frame(1, 2'b00, "n4_pad");
    finish_frame();
    wait_idle("n4_pad");
    sel4 = 1'b0;
  endtask

  task automatic test_len(input int len, input string name);
    sel4 = 1'b0;
    len0 = 11'(len);
    req2 = 2'b01;
    push_frame(0, len);
    collect_frame(0, 2'b00, name);
    finish_frame();
    wait_idle(name);
  endtask

  task automatic test_timeout();
    int k, j, errcnt;
    len0 = 11'd46;
    req2 = 2'b01;
    push_frame(0, 46);
    collect_frame(0, 2'b00, "timeout_frame");
    k = 0;
    while (!err2 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k !== 4096) begin
      miscompares++;
      $display("FAIL timeout_delay: err after %0d cycles, required 4096", k);
    end
    vectors++;
    if (gnt2 !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_gnt: got gnt=%b, required 00", gnt2);
    end
    j = 0;
    errcnt = 0;
    while (busy2 && j < 200) begin
      if (err2) errcnt++;
      @(negedge clk);
      j++;
    end
    vectors++;
    if (j !== 48 || errcnt !== 1) begin
      miscompares++;
      $display("FAIL timeout_ifg: IFG %0d cycles with %0d err pulses, required 48 and 1", j, errcnt);
    end
  endtask

  task automatic test_ifg();
    int i, lowcnt;
    len0 = 11'd46;
    req2 = 2'b01;
    push_frame(0, 46);
    collect_frame(0, 2'b01, "ifg_frame");
    finish_frame();
    vectors++;
    if ({gnt2, busy2} !== 3'b001) begin
      miscompares++;
      $display("FAIL ifg_entry: got gnt=%b busy=%b, required 00 1", gnt2, busy2);
    end
    i = 0;
    lowcnt = 0;
    while (gnt2 == 2'b00 && i < 200) begin
      if (!busy2) lowcnt++;
      @(negedge clk);
      i++;
    end
    vectors++;
    if (i !== 49 || lowcnt !== 1) begin
      miscompares++;
      $display("FAIL ifg_regrant: grant after %0d cycles with %0d idle cycles, required 49 and 1", i, lowcnt);
    end
    push_frame(0, 46);
    collect_frame(0, 2'b00, "ifg_next");
    finish_frame();
    wait_idle("ifg_next");
  endtask

  task automatic test_rst_mid();
    len0 = 11'd60;
    req2 = 2'b01;
    @(negedge clk);
    req2 = 2'b00;
    repeat (10) @(negedge clk);
    vectors++;
    if (axiiv2 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got tx_axiiv=%b, required 1", axiiv2);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({gnt2, rd2, axiiv2, axiid2, etype_o2, mac_o2, busy2, err2} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got gnt=%b rd=%b v=%b d=%h et=%h mac=%h busy=%b err=%b, required all 0",
               gnt2, rd2, axiiv2, axiid2, etype_o2, mac_o2, busy2, err2);
    end
    @(negedge clk);
    rst = 1'b0;
    req2 = 2'b11;
    @(negedge clk);
    vectors++;
    if ({gnt2, err2} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_mid_regrant: got gnt=%b err=%b, required 01 0", gnt2, err2);
    end
    req2 = 2'b00;
    reset_dut();
  endtask

  initial begin
    rst = 1'b1; req2 = 2'b00; req4 = 2'b00; sel4 = 1'b0;
    axiov2 = 1'b0; axiov4 = 1'b0;
    len0 = '0; len1 = '0; etype0 = '0; etype1 = '0; mac0 = '0; mac1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pad_n4();
    test_len(0, "len0_pad_only");
    test_len(45, "len45_short_pad");
    test_len(46, "len46_no_pad");
    test_len(2000, "len2000_clamped");
    test_timeout();
    test_ifg();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001: Parameter N, default 2, data width in bits per cycle (2 or 4).
REQ-002: Parameter IFG_CYCLES, default 96/N, inter-frame gap length in cycles.
REQ-003: Parameter DONE_TIMEOUT, default 4096, maximum cycles to wait for frame end.
REQ-004: clk  input  1  system clock (25 or 50 MHz).
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: req  input  2  per-requester frame request, bit k = requester k.
REQ-007: len0, len1  input  11 each  payload length in bytes.
REQ-008: etype0, etype1  input  16 each  Ethernet type per requester.
REQ-009: dest_mac0, dest_mac1  input  48 each  destination MAC per requester.
REQ-010: data0, data1  input  N each  payload data per requester.
REQ-011: gnt  output  2  one-hot grant.
REQ-012: rd  output  2  bit k high = data_k consumed this cycle.
REQ-013: tx_axiiv  output  1  valid to the Ethernet transmitter.
REQ-014: tx_axiid  output  N  data to the Ethernet transmitter.
REQ-015: tx_etype  output  16  latched Ethernet type of the current frame.
REQ-016: tx_dest_mac  output  48  latched destination MAC of the current frame.
REQ-017: tx_axiov  input  1  transmitter output valid; its falling edge marks frame end.
REQ-018: busy  output  1  high in any state other than IDLE.
REQ-019: err  output  1  one-cycle pulse on frame-end timeout.

Function
REQ-020: States SHALL be IDLE, STREAM, PAD, WAIT_DONE and IFG.
REQ-021: In IDLE with req nonzero, the block SHALL grant one requester and enter STREAM next cycle.
REQ-022: Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset requester 0 wins.
REQ-023: On grant, gnt, len (clamped to 1500), tx_etype and tx_dest_mac SHALL be latched and held until the next grant.
REQ-024: STREAM SHALL last exactly len*8/N cycles; tx_axiiv=1, tx_axiid=data_g and rd[g]=1 combinationally (g = granted index); rd of the other requester stays 0.
REQ-025: If latched len < 46, PAD SHALL follow STREAM for (46-len)*8/N cycles with tx_axiiv=1, tx_axiid=0, rd=0; otherwise PAD is skipped.
REQ-026: len=0 SHALL skip STREAM entirely and go straight to PAD (368/N cycles).
REQ-027: In WAIT_DONE, tx_axiiv SHALL be 0; the block SHALL go to IFG on the first cycle where tx_axiov was 1 on the previous cycle and is 0 now.
REQ-028: If the falling edge does not arrive within DONE_TIMEOUT cycles of entering WAIT_DONE, err SHALL pulse one cycle and the block SHALL go to IFG.
REQ-029: gnt SHALL fall on entering IFG; IFG SHALL last exactly IFG_CYCLES cycles, then return to IDLE.
REQ-030: New requests in IFG SHALL be ignored until IDLE; req deasserted mid-frame SHALL NOT shorten the frame.
REQ-031: tx_axiiv SHALL be 0 in IDLE, WAIT_DONE and IFG, giving one rising edge per frame.
REQ-032: Beat and timeout counters SHALL be wide enough to count 12000 beats without wrap.

Reset
REQ-033: rst SHALL asynchronously force state IDLE, gnt=0, rd=0, tx_axiiv=0, tx_axiid=0, tx_etype=0, tx_dest_mac=0, busy=0, err=0, counters=0 and the round-robin pointer to favor requester 0.
REQ-034: rst mid-frame SHALL abort the frame immediately, with no err pulse; the first grant after release SHALL follow REQ-022.

Verification
REQ-035: N=2, req=01, len0=60, data0 incrementing -> gnt=01 one cycle later; tx_axiiv high for exactly 240 cycles with rd[0]=1; no PAD.
REQ-036: N=2, req=11 from reset, both len=64 -> requester 0 served first, requester 1 second; gnt never 11.
REQ-037: N=4, len1=10, req=10 -> 20 STREAM cycles with data1, then 72 PAD cycles with tx_axiid=0; total tx_axiiv high for 92 cycles.
REQ-038: tx_axiov held at 0 after the payload ends -> err pulses once, 4096 cycles after WAIT_DONE entry; state goes IFG, then IDLE after 48 cycles (N=2).
REQ-039: Drive tx_axiov falling edge; hold req=01 throughout IFG -> no grant during the 48 IFG cycles, new grant on the first IDLE cycle.
REQ-040: Assert rst 10 cycles into STREAM -> all outputs 0 immediately; after release, req=11 grants requester 0.
